// File: rtl/clock_mode_ctrl_if.sv
// ============================================================================
// Module      : clock_mode_ctrl_if
// Description : Button, halt and clock-switch control signals of clock_mode_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clock_mode_ctrl_if;
    logic mode_btn;
    logic step_btn;
    logic hlt;
    logic sel;
    logic man_clk;
    logic settling;
    logic run_active;

    modport master (
        output mode_btn, step_btn, hlt,
        input  sel, man_clk, settling, run_active
    );

    modport slave (
        input  mode_btn, step_btn, hlt,
        output sel, man_clk, settling, run_active
    );
endinterface

`default_nettype wire

// File: rtl/clock_mode_ctrl.sv
// ============================================================================
// Module      : clock_mode_ctrl
// Description : Debounced manual/auto clock-source controller with single-step.
//               Optional macro CLKCTRL_HLT_AUTOSTOP_EN: hlt leaves AUTO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int SETTLE_CYCLES    = 8,
    parameter int STEP_HIGH_CYCLES = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    clock_mode_ctrl_if.slave bus
);

    localparam logic [15:0] c_DB_LAST     = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  c_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  c_STEP_LAST   = 8'(STEP_HIGH_CYCLES - 1);

    typedef enum logic [1:0] {
        MANUAL    = 2'd0,
        SETTLE_UP = 2'd1,
        AUTO      = 2'd2,
        SETTLE_DN = 2'd3
    } state_t;

    logic [1:0] w_raw;
    logic [1:0] w_evt;
    logic       w_mode_evt;
    logic       w_step_evt;

    assign w_raw      = {bus.step_btn, bus.mode_btn};
    assign w_mode_evt = w_evt[0];
    assign w_step_evt = w_evt[1];

    generate
        for (genvar g = 0; g < 2; g++) begin : g_btn
            logic        r_s1;
            logic        r_s2;
            logic        r_deb;
            logic        r_deb_d;
            logic [15:0] r_cnt;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_s1    <= 1'b0;
                    r_s2    <= 1'b0;
                    r_deb   <= 1'b0;
                    r_deb_d <= 1'b0;
                    r_cnt   <= 16'd0;
                end else begin
                    r_s1    <= w_raw[g];
                    r_s2    <= r_s1;
                    r_deb_d <= r_deb;
                    // Any cycle agreeing with the accepted level restarts the count
                    if (r_s2 == r_deb) begin
                        r_cnt <= 16'd0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_deb <= r_s2;
                        r_cnt <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
            end

            assign w_evt[g] = r_deb & ~r_deb_d;
        end
    endgenerate

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_set_cnt;
    logic [7:0] r_step_cnt;
    logic       r_sel;
    logic       r_man_clk;
    logic       r_settling;
    logic       r_run_active;
    logic       w_auto_stop;
    logic       w_step_start;

`ifdef CLKCTRL_HLT_AUTOSTOP_EN
    assign w_auto_stop = w_mode_evt | bus.hlt;
`else
    assign w_auto_stop = w_mode_evt;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_step_start = 1'b0;
        case (r_state)
            MANUAL: begin
                if (w_mode_evt && !bus.hlt && !r_man_clk) begin
                    w_state_nxt = SETTLE_UP;
                end else if (w_step_evt && !r_man_clk) begin
                    w_step_start = 1'b1;
                end
            end
            SETTLE_UP: begin
                if (r_set_cnt == c_SETTLE_LAST) w_state_nxt = AUTO;
            end
            AUTO: begin
                if (w_auto_stop) w_state_nxt = SETTLE_DN;
            end
            SETTLE_DN: begin
                if (r_set_cnt == c_SETTLE_LAST) w_state_nxt = MANUAL;
            end
            default: w_state_nxt = MANUAL;
        endcase
    end

    // Outputs are registered from the next state so they change on the transition edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= MANUAL;
            r_set_cnt    <= 8'd0;
            r_sel        <= 1'b0;
            r_settling   <= 1'b0;
            r_run_active <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_set_cnt    <= (w_state_nxt != r_state) ? 8'd0 : r_set_cnt + 8'd1;
            r_sel        <= (w_state_nxt == SETTLE_UP) || (w_state_nxt == AUTO);
            r_settling   <= (w_state_nxt == SETTLE_UP) || (w_state_nxt == SETTLE_DN);
            r_run_active <= (w_state_nxt == AUTO);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_man_clk  <= 1'b0;
            r_step_cnt <= 8'd0;
        end else if (w_step_start) begin
            r_man_clk  <= 1'b1;
            r_step_cnt <= 8'd0;
        end else if (r_man_clk) begin
            if (r_step_cnt == c_STEP_LAST) begin
                r_man_clk <= 1'b0;
            end
            r_step_cnt <= r_step_cnt + 8'd1;
        end
    end

    assign bus.sel        = r_sel;
    assign bus.man_clk    = r_man_clk;
    assign bus.settling   = r_settling;
    assign bus.run_active = r_run_active;

endmodule

`default_nettype wire

// File: doc/clock_mode_ctrl.md
CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, named as in the table below.
REQ-002 Parameter DEBOUNCE_CYCLES SHALL default to 16; it sets the consecutive stable cycles needed to accept a button level (range 2..65535).
REQ-003 Parameter SETTLE_CYCLES SHALL default to 8; it sets the cycles that `settling` is held after any `sel` change (range 1..255).
REQ-004 Parameter STEP_HIGH_CYCLES SHALL default to 4; it sets the high time of a manual clock pulse (range 1..255).
REQ-005 The ports SHALL be as follows:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- mode_btn  in  1  raw, asynchronous mode-toggle button, active-high.
- step_btn  in  1  raw, asynchronous single-step button, active-high.
- hlt  in  1  CPU halt flag, synchronous to clk.
- sel  out  1  clock-switch source select; 0 = manual clock, 1 = auto clock.
- man_clk  out  1  manual step clock fed to the switch's clk0 input; registered.
- settling  out  1  a `sel` change is in progress.
- run_active  out  1  the auto clock is selected and settled.

Function
REQ-006 Each button SHALL pass through a 2-flop synchronizer, then a debounce counter.
REQ-007 The debounced level SHALL change only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch break SHALL clear the counter.
REQ-008 A press event SHALL be a one-cycle pulse on a 0->1 transition of the debounced level; releases SHALL generate no event.
REQ-009 The FSM SHALL have four states: MANUAL, SETTLE_UP, AUTO, SETTLE_DN.
REQ-010 MANUAL SHALL transition to SETTLE_UP on a mode event when hlt=0 and man_clk=0; on that edge sel SHALL go to 1 and settling SHALL go to 1.
REQ-011 SETTLE_UP SHALL hold settling=1 for exactly SETTLE_CYCLES cycles, then enter AUTO.
REQ-012 In AUTO, run_active SHALL be 1 from the first AUTO cycle until the edge that leaves AUTO.
REQ-013 AUTO SHALL transition to SETTLE_DN on a mode event; on that edge sel SHALL go to 0, settling SHALL go to 1, and run_active SHALL go to 0.
REQ-014 SETTLE_DN SHALL hold settling=1 for exactly SETTLE_CYCLES cycles, then enter MANUAL.
REQ-015 In MANUAL with settling=0, a step event while man_clk=0 SHALL drive man_clk=1 for exactly STEP_HIGH_CYCLES cycles, then 0.
REQ-016 Step events SHALL be dropped in all other states and while a pulse is active; they SHALL NOT be queued.
REQ-017 Mode events in SETTLE_UP or SETTLE_DN, or while man_clk=1, SHALL be dropped.
REQ-018 A mode event and a step event in the same MANUAL cycle SHALL take the mode transition and drop the step event.
REQ-019 With a raw button change at edge 0 that stays stable, the resulting sel or man_clk change SHALL appear at edge DEBOUNCE_CYCLES+3.
REQ-020 sel SHALL be constant outside the transition edges given in REQ-010 and REQ-013.
REQ-021 man_clk SHALL be 0 whenever sel=1.

Reset
REQ-022 While rst_n=0 at a clk edge, the block SHALL reset the following: state = MANUAL; sel, man_clk, settling, run_active = 0; synchronizers, debounced levels, and all counters = 0.
REQ-023 Reset SHALL override any in-progress pulse, settle, or debounce, with no residual event after rst_n rises.
REQ-024 A button held high through reset SHALL produce one press event after DEBOUNCE_CYCLES+3 cycles following the release of reset.

Configuration
REQ-025 With macro CLKCTRL_HLT_AUTOSTOP_EN defined, hlt=1 in AUTO SHALL force the AUTO->SETTLE_DN transition on the next edge, identical to a mode event; hlt and a mode event in the same cycle SHALL produce a single transition.
REQ-026 Without CLKCTRL_HLT_AUTOSTOP_EN, hlt SHALL be ignored in AUTO; its MANUAL-state gating (REQ-010) SHALL still apply.

Verification (defaults 16/8/4)
REQ-027 Reset, then mode_btn held high from edge 0 -> sel=1 and settling=1 at edge 19; settling=0 and run_active=1 at edge 27.
REQ-028 In MANUAL, step_btn held high -> man_clk high for exactly 4 cycles starting at edge 19; bounce of 10 cycles high / 1 low / 10 high -> no pulse until 16 stable cycles.
REQ-029 In MANUAL, mode and step events in the same cycle -> sel=1, man_clk stays 0 throughout.
REQ-030 In SETTLE_UP, a second mode press -> ignored; AUTO is reached at the nominal cycle.
REQ-031 With CLKCTRL_HLT_AUTOSTOP_EN, hlt=1 in AUTO -> sel=0 on the next edge and MANUAL after 8 cycles; without the macro -> sel stays 1.
REQ-032 rst_n=0 for one edge mid-pulse and mid-settle -> all outputs 0 next cycle, state MANUAL.
